// File: rtl/activations_fetch.sv
// Streams a contiguous run of activation SRAM words to the unpacking stage over
// a valid/ready handshake, using a 3-entry skid FIFO to cover the read latency.
module activations_fetch #(
  parameter int MEM_BW        = 128,
  parameter int IO_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_BW-1:0]     mem_rdata,
  output logic [MEM_BW-1:0]     act_word,
  output logic                  act_valid,
  input  logic                  act_ready
);

  if (MEM_BW % IO_DATA_WIDTH != 0) begin : g_bad_width
    $error("MEM_BW must be a multiple of IO_DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic                  mem_re_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic [ADDR_WIDTH-1:0] delivered_q;
  logic                  inflight_q;
  logic [1:0]            count_q;
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [MEM_BW-1:0]     fifo_q [3];

  logic       push;
  logic       pop;
  logic       last_pop;
  logic       issue_ok;
  logic [1:0] count_nx;

  // mem_re is registered one cycle ahead, so the issue check looks at next-cycle
  // occupancy plus the read currently on the bus (which becomes inflight next).
  always_comb begin
    push     = inflight_q;
    pop      = (count_q != 2'd0) && act_ready;
    count_nx = count_q + {1'b0, push} - {1'b0, pop};
    last_pop = pop && ((delivered_q + ADDR_WIDTH'(1)) == len_q);
    issue_ok = (issued_q < len_q) &&
               (({1'b0, count_nx} + {2'b0, mem_re_q}) < 3'd3);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      mem_re_q    <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      inflight_q <= mem_re_q;
      count_q    <= count_nx;
      mem_re_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              state       <= RUN;
              len_q       <= num_words;
              issued_q    <= ADDR_WIDTH'(1);
              delivered_q <= '0;
              mem_re_q    <= 1'b1;
              addr_q      <= base_addr;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (pop) delivered_q <= delivered_q + ADDR_WIDTH'(1);
          if (last_pop) state <= DONE;
          if (issue_ok) begin
            mem_re_q <= 1'b1;
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            issued_q <= issued_q + ADDR_WIDTH'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Circular storage; pointers wrap at 3.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < 3; i++) begin
          if (wr_ptr_q == 2'(i)) fifo_q[i] <= mem_rdata;
        end
        wr_ptr_q <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
  end

  always_comb begin
    case (rd_ptr_q)
      2'd1:    act_word = fifo_q[1];
      2'd2:    act_word = fifo_q[2];
      default: act_word = fifo_q[0];
    endcase
  end

  assign act_valid = (count_q != 2'd0);
  assign mem_re    = mem_re_q;
  assign mem_addr  = addr_q;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_activations_fetch.sv
// Scoreboard bench for activations_fetch: stimulus queues expected reads/words,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_activations_fetch;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  num_words = '0;
  logic         busy;
  logic         done;
  logic         mem_re;
  logic [15:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic [127:0] act_word;
  logic         act_valid;
  logic         act_ready = 1'b0;

  int checks = 0;
  int fails = 0;
  int tick = 0;
  int t0 = 0;
  int monRel;
  int reCount, reBefore10, hsCount, validCount, busyCount, doneCount;
  int doneRel, lastHsRel, firstValidRel, firstReRel;
  logic [15:0]  expAddrQ[$];
  logic [127:0] expWordQ[$];
  logic [15:0]  addrLog[$];
  logic [15:0]  wrapAddrs[4];

  activations_fetch #(.MEM_BW(128), .IO_DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .arst(arst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .act_word(act_word),
    .act_valid(act_valid), .act_ready(act_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  function automatic logic [127:0] wordAt(input logic [15:0] a);
    return {a, {7{a ^ 16'hA5C3}}};
  endfunction

  // One-cycle-latency SRAM model
  always @(posedge clk) if (mem_re) mem_rdata <= wordAt(mem_addr);

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic resetCounters();
    reCount = 0; reBefore10 = 0; hsCount = 0; validCount = 0; busyCount = 0;
    doneCount = 0; doneRel = -1; lastHsRel = -1; firstValidRel = -1; firstReRel = -1;
    addrLog.delete();
  endtask

  task automatic applyStimulus(input logic [15:0] base, input logic [15:0] num);
    logic [15:0] a;
    resetCounters();
    a = base;
    for (int i = 0; i < int'(num); i++) begin
      expAddrQ.push_back(a);
      expWordQ.push_back(wordAt(a));
      a = a + 16'd1;
    end
    @(negedge clk);
    start = 1'b1; base_addr = base; num_words = num;
    @(posedge clk);
    #1;
    t0 = tick;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && doneCount == 0; i++) @(negedge clk);
    if (doneCount == 0) begin
      checks++; fails++;
      $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", budget);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      monRel = tick - t0;
      if (mem_re) begin
        reCount++;
        if (monRel < 10) reBefore10++;
        if (firstReRel < 0) firstReRel = monRel;
        addrLog.push_back(mem_addr);
        if (expAddrQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected_read: got addr %0h, expected no read", mem_addr);
        end else checkOutput("mem_addr", 128'(mem_addr), 128'(expAddrQ.pop_front()));
      end
      if (act_valid) begin
        validCount++;
        if (firstValidRel < 0) firstValidRel = monRel;
      end
      if (act_valid && act_ready) begin
        hsCount++;
        lastHsRel = monRel;
        if (expWordQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word", act_word);
        end else checkOutput("act_word", act_word, expWordQ.pop_front());
      end
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        doneRel = monRel;
      end
    end
  end

  initial begin
    int rel;
    wrapAddrs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    resetCounters();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 128'(busy), 0);
    checkOutput("reset_done", 128'(done), 0);
    checkOutput("reset_mem_re", 128'(mem_re), 0);
    checkOutput("reset_act_valid", 128'(act_valid), 0);
    checkOutput("reset_mem_addr", 128'(mem_addr), 0);
    checkOutput("reset_act_word", act_word, 0);
    arst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] basic transfer");
    act_ready = 1'b1;
    applyStimulus(16'h0010, 16'd4);
    waitDone(50);
    checkOutput("basic_re_count", 128'(reCount), 4);
    checkOutput("basic_first_re", 128'(firstReRel), 0);
    checkOutput("basic_first_valid", 128'(firstValidRel), 2);
    checkOutput("basic_last_hs", 128'(lastHsRel), 5);
    checkOutput("basic_hs_count", 128'(hsCount), 4);
    checkOutput("basic_done_cycle", 128'(doneRel), 6);
    checkOutput("basic_done_count", 128'(doneCount), 1);
    checkOutput("basic_busy_cycles", 128'(busyCount), 6);

    $display("[TB] backpressure");
    act_ready = 1'b0;
    applyStimulus(16'h0200, 16'd8);
    for (int i = 0; i < 200 && doneCount == 0; i++) begin
      @(posedge clk);
      #1;
      rel = tick - t0;
      act_ready = (rel >= 10) ? ((rel - 10) % 2 == 0) : 1'b0;
    end
    if (doneCount == 0) begin
      checks++; fails++;
      $display("[TB] FAIL bp_timeout: got no done, expected done within 200 cycles");
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput("bp_reads_before_10", 128'(reBefore10), 3);
    checkOutput("bp_hs_count", 128'(hsCount), 8);
    checkOutput("bp_done_after_hs", 128'(doneRel), 128'(lastHsRel + 1));
    checkOutput("bp_done_count", 128'(doneCount), 1);
    checkOutput("bp_words_left", 128'(expWordQ.size()), 0);

    $display("[TB] zero length");
    act_ready = 1'b1;
    applyStimulus(16'h0077, 16'd0);
    waitDone(10);
    checkOutput("zero_done_cycle", 128'(doneRel), 0);
    checkOutput("zero_re_count", 128'(reCount), 0);
    checkOutput("zero_busy_cycles", 128'(busyCount), 0);
    checkOutput("zero_valid_cycles", 128'(validCount), 0);

    $display("[TB] start while busy");
    applyStimulus(16'h0030, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 16'h0100; num_words = 16'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(50);
    checkOutput("busy_start_re_count", 128'(reCount), 4);
    checkOutput("busy_start_done_count", 128'(doneCount), 1);
    checkOutput("busy_start_words_left", 128'(expWordQ.size()), 0);

    $display("[TB] reset mid-operation");
    applyStimulus(16'h0050, 16'd8);
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b1;
    #1;
    checkOutput("midrst_busy", 128'(busy), 0);
    checkOutput("midrst_done", 128'(done), 0);
    checkOutput("midrst_mem_re", 128'(mem_re), 0);
    checkOutput("midrst_act_valid", 128'(act_valid), 0);
    checkOutput("midrst_mem_addr", 128'(mem_addr), 0);
    checkOutput("midrst_act_word", act_word, 0);
    expAddrQ.delete();
    expWordQ.delete();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    resetCounters();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_no_valid", 128'(validCount), 0);
    applyStimulus(16'h0020, 16'd2);
    waitDone(50);
    checkOutput("midrst_restart_hs", 128'(hsCount), 2);
    checkOutput("midrst_restart_left", 128'(expWordQ.size()), 0);

    $display("[TB] address wrap");
    applyStimulus(16'hFFFE, 16'd4);
    waitDone(50);
    checkOutput("wrap_read_count", 128'(addrLog.size()), 4);
    for (int i = 0; i < 4 && i < addrLog.size(); i++)
      checkOutput("wrap_addr", 128'(addrLog[i]), 128'(wrapAddrs[i]));
    checkOutput("wrap_hs_count", 128'(hsCount), 4);
    checkOutput("wrap_words_left", 128'(expWordQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/activations_fetch.md
# activations_fetch

Sequential read controller for the activation SRAM. On a start pulse it streams a contiguous run of MEM_BW-bit words out of the SRAM (1-cycle read latency) and hands them, in address order, to the activation unpacking stage over a valid/ready handshake. A 3-entry skid FIFO absorbs the SRAM latency so the stage sustains one word per cycle under continuous ready and never drops data under backpressure.

## Interface
- MEM_BW, 128, SRAM word width in bits; activation 0 occupies bits [MEM_BW-1 -: IO_DATA_WIDTH]
- IO_DATA_WIDTH, 8, activation width; MEM_BW must be a multiple of it
- ADDR_WIDTH, 16, SRAM address and word-count width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- arst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, sampled with start
- num_words  in  ADDR_WIDTH  words to transfer, sampled with start; 0 is legal
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the transfer completes
- mem_re  out  1  SRAM read enable
- mem_addr  out  ADDR_WIDTH  SRAM read address
- mem_rdata  in  MEM_BW  SRAM data, valid the cycle after the mem_re cycle
- act_word  out  MEM_BW  head word to the unpacking stage
- act_valid  out  1  act_word valid
- act_ready  in  1  downstream accepts; handshake when act_valid && act_ready

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start && num_words!=0 -> RUN. Latch base_addr into the address counter and num_words into the length register. Clear the issued and delivered counters.
- IDLE: start && num_words==0 -> DONE. No read is issued.
- RUN: issue a read (mem_re=1, mem_addr=current address, then increment the address) when issued<length and fifo_count+inflight<3. Both fifo_count and inflight are registered values; there is no combinational path from act_ready to mem_re.
- inflight is a 1-bit flag. It is set on the cycle a read is issued. The returned mem_rdata is pushed into the FIFO on the following edge, unconditionally. Space for it is guaranteed by the issue rule.
- FIFO: depth 3, first-in first-out. act_valid = (fifo_count!=0). act_word = head entry. A pop happens on handshake. Push and pop in the same cycle leave the count unchanged.
- RUN -> DONE on the edge where a handshake makes delivered reach the length.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- start outside IDLE is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH, so the address wraps from all-ones to 0.
- Words pass through unmodified. The bit order is preserved for the unpacking stage.

## Timing
- Cycle n is the interval following rising edge n; start is sampled at edge 0.
- Reads: mem_re is asserted in cycles 0..N-1 with addresses base..base+N-1, given continuous act_ready.
- First act_valid is in cycle 2. Word k is presented in cycle 2+k with continuous act_ready.
- done is asserted in cycle N+2. busy is high in cycles 0..N+1.
- Throughput is 1 word per cycle in steady state. With act_ready=0, at most 3 reads are issued before mem_re stays low.
- mem_addr holds its last value when mem_re=0. act_word is don't-care when act_valid=0.
- Reset values (async, immediate on arst): state IDLE; busy, done, mem_re, act_valid, inflight, fifo_count = 0; mem_addr = 0; act_word = 0.
- Reset mid-transfer discards FIFO contents and any in-flight read. mem_rdata arriving after reset release is ignored.

## Test plan
- Basic transfer: after reset, start with base=0x0010, num=4, act_ready=1, SRAM word at address a = {a, pattern}. Required: mem_re in cycles 0-3 with addresses 0x10-0x13; act_valid in cycles 2-5 carrying words 0x10-0x13 in order; done in cycle 6 only; busy in cycles 0-5.
- Backpressure: num=8 with act_ready=0 from cycle 0 until cycle 10, then toggled 1/0 every cycle. Required: exactly 3 mem_re pulses before cycle 10; all 8 words delivered once each, in order; done one cycle after the 8th handshake.
- Zero length: start with num=0. Required: done=1 in cycle 0; mem_re, busy and act_valid never assert.
- Start while busy: second start (base=0x0100) in cycle 3 of a num=4 run. Required: ignored; only addresses of the first run are read; single done pulse.
- Reset mid-operation: assert arst in cycle 3 of a num=8 run, while a read is in flight. Required: all outputs go to 0 immediately; no act_valid after release; a fresh start with base=0x0020, num=2 then delivers words 0x20 and 0x21 only.
- Address wrap: base=0xFFFE, num=4, ADDR_WIDTH=16. Required: mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; data delivered in that order.
